// File: rtl/activation_drain.sv
// -----------------------------------------------------------------------------
// activation_drain
// Output stage behind `activation`. It tracks each beat issued to the
// activation pipeline, catches the post-activation vector on the cycle it
// emerges, buffers it in a small FIFO and hands it downstream over
// valid/ready. Each tile's final beat is marked with last_o.
// Credit-style ready_o counts both the buffered beats and the beats still
// inside the activation pipeline, so an upstream issuer that honours it can
// never overflow the FIFO.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous flush of all state; wins over every other event
//   calc_en_i     a beat enters `activation` this cycle (always accepted)
//   ready_o       upstream may issue (occupancy < DEPTH); registered
//   act_data_i    `activation` data_o, N_PE lanes of WO bits
//   tile_beats_i  beats per tile; 0 behaves as 1
//   valid_o       data_o/last_o hold a buffered beat
//   ready_i       downstream accepts the beat this cycle
//   data_o        head-of-FIFO vector; registered, no fall-through
//   last_o        head beat is the final beat of its tile
//   err_o         sticky: a beat arrived while the FIFO was full
// -----------------------------------------------------------------------------
module activation_drain #(
   parameter int unsigned N_PE        = 16,
   parameter int unsigned WO          = 8,
   parameter int unsigned ACT_LATENCY = 2,
   parameter int unsigned DEPTH       = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 calc_en_i,
   output logic                 ready_o,
   input  logic [N_PE*WO-1:0]   act_data_i,
   input  logic [15:0]          tile_beats_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [N_PE*WO-1:0]   data_o,
   output logic                 last_o,
   output logic                 err_o
);

   localparam int unsigned DW    = N_PE * WO;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   // Wide enough for a full FIFO plus a full tag pipeline (overrun case).
   localparam int unsigned OCC_W = $clog2(DEPTH + ACT_LATENCY + 1);

   // Tag pipeline mirrors the activation's register depth, one bit per stage.
   logic [ACT_LATENCY-1:0] tag_q, tag_d;

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [15:0]            beat_cnt_q, beat_cnt_d;

   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic                   err_q, err_d;
   logic                   ready_q, ready_d;
   logic [DW-1:0]          data_q, data_d;

   logic [DW-1:0]          mem_q [DEPTH];

   logic                   tap;
   logic                   pop;
   logic                   full;
   logic                   push_ok;
   logic                   drop;
   logic [15:0]            tile_m1;
   logic [OCC_W-1:0]       inflight_d;
   logic [OCC_W-1:0]       occ_d;

   // Event decode for this cycle.
   always_comb begin
      tap     = tag_q[ACT_LATENCY-1];
      pop     = valid_q && ready_i;
      full    = (count_q == CNT_W'(DEPTH));
      // A pop in the same cycle frees the slot, so a full FIFO can still push.
      push_ok = tap && (!full || pop);
      drop    = tap && full && !pop;
      tile_m1 = (tile_beats_i == 16'd0) ? 16'd0 : (tile_beats_i - 16'd1);
   end

   // Next-state for tags, FIFO bookkeeping, tile counter and registered outputs.
   always_comb begin
      tag_d      = ACT_LATENCY'({tag_q, calc_en_i});
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      ready_d    = 1'b1;
      inflight_d = '0;
      occ_d      = '0;

      if (clear_i) begin
         tag_d      = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         beat_cnt_d = '0;
         err_d      = 1'b0;
         data_d     = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            beat_cnt_d = last_q ? 16'd0 : (beat_cnt_q + 16'd1);
         end
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
         if (drop) begin
            err_d = 1'b1;
         end

         // Preload the next head; it may be the beat being written right now.
         if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
               data_d = act_data_i;
            end else begin
               data_d = mem_q[rd_ptr_d];
            end
         end

         valid_d = (count_d != '0);
         last_d  = valid_d && (beat_cnt_d == tile_m1);

         for (int unsigned i = 0; i < ACT_LATENCY; i++) begin
            inflight_d = inflight_d + OCC_W'(tag_d[i]);
         end
         occ_d   = OCC_W'(count_d) + inflight_d;
         ready_d = (occ_d < OCC_W'(DEPTH));
      end
   end

   // Control and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         beat_cnt_q <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         data_q     <= '0;
      end else begin
         tag_q      <= tag_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         beat_cnt_q <= beat_cnt_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
         data_q     <= data_d;
      end
   end

   // FIFO storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push_ok && !clear_i) begin
         mem_q[wr_ptr_q] <= act_data_i;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_activation_drain.sv
// Self-checking bench for activation_drain: a per-cycle vector table, directed
// corner sequences, and a randomized run. Every cycle is also compared against
// a queue-based model of the drain.
module tb_activation_drain;

   localparam int unsigned N_PE        = 16;
   localparam int unsigned WO          = 8;
   localparam int unsigned ACT_LATENCY = 2;
   localparam int unsigned DEPTH       = 8;
   localparam int unsigned DW          = N_PE * WO;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            clear_i;
   logic            calc_en_i;
   logic            ready_o;
   logic [DW-1:0]   act_data_i;
   logic [15:0]     tile_beats_i;
   logic            valid_o;
   logic            ready_i;
   logic [DW-1:0]   data_o;
   logic            last_o;
   logic            err_o;

   activation_drain #(
      .N_PE(N_PE), .WO(WO), .ACT_LATENCY(ACT_LATENCY), .DEPTH(DEPTH)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .calc_en_i(calc_en_i),
      .ready_o(ready_o), .act_data_i(act_data_i), .tile_beats_i(tile_beats_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
      .err_o(err_o)
   );

   initial forever #5 clk_i = ~clk_i;

   int n_cmp;
   int n_bad;
   int cyc;
   int pops;
   int last_idx[$];

   // Model: buffered beats, beats inside activation (issue cycle + payload),
   // beats popped in the current tile, sticky error.
   logic [DW-1:0] m_fifo[$];
   int            m_iss_cyc[$];
   logic [DW-1:0] m_iss_dat[$];
   int            m_bc;
   logic          m_err;

   typedef struct {
      logic        ce;
      logic [7:0]  lane;
      logic        rdy;
      logic [15:0] tile;
      logic        e_valid;
      logic        e_last;
      logic        e_ready;
      logic        e_err;
      logic [7:0]  e_lane;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rep(input logic [7:0] v);
      return {N_PE{v}};
   endfunction

   function automatic logic [DW-1:0] junk();
      logic [DW-1:0] r;
      for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic m_ready();
      return (m_fifo.size() + m_iss_cyc.size()) < int'(DEPTH);
   endfunction

   function automatic int tile_m1();
      return (tile_beats_i == 16'd0) ? 0 : int'(tile_beats_i) - 1;
   endfunction

   task automatic m_flush();
      m_fifo.delete();
      m_iss_cyc.delete();
      m_iss_dat.delete();
      m_bc  = 0;
      m_err = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance.
   task automatic tick(input logic ce, input logic [DW-1:0] p, input logic rdy, input logic clr);
      logic          tap;
      logic          mv;
      logic [DW-1:0] d;
      calc_en_i = ce;
      ready_i   = rdy;
      clear_i   = clr;
      tap = (m_iss_cyc.size() != 0) && (m_iss_cyc[0] == cyc - int'(ACT_LATENCY));
      act_data_i = tap ? m_iss_dat[0] : junk();

      mv = (m_fifo.size() != 0);
      chk("valid", DW'(valid_o), DW'(mv));
      chk("ready", DW'(ready_o), DW'(m_ready()));
      chk("err", DW'(err_o), DW'(m_err));
      chk("last", DW'(last_o), DW'(mv && (m_bc == tile_m1())));
      if (mv) chk("data", data_o, m_fifo[0]);
      if (valid_o && rdy) begin
         pops++;
         if (last_o) last_idx.push_back(pops);
      end

      if (clr) begin
         m_flush();
      end else begin
         d = '0;
         if (tap) begin
            d = m_iss_dat.pop_front();
            void'(m_iss_cyc.pop_front());
         end
         if (mv && rdy) begin
            void'(m_fifo.pop_front());
            m_bc = (m_bc == tile_m1()) ? 0 : m_bc + 1;
         end
         if (tap) begin
            if (m_fifo.size() < int'(DEPTH)) m_fifo.push_back(d);
            else m_err = 1'b1;
         end
         if (ce) begin
            m_iss_cyc.push_back(cyc);
            m_iss_dat.push_back(p);
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   // Asynchronous reset held for one edge; outputs must react immediately.
   task automatic async_reset(input string tag);
      calc_en_i = 1'b0;
      clear_i   = 1'b0;
      ready_i   = 1'b0;
      rst_ni    = 1'b0;
      #1;
      chk({tag, "_valid"}, DW'(valid_o), DW'(1'b0));
      chk({tag, "_last"},  DW'(last_o),  DW'(1'b0));
      chk({tag, "_err"},   DW'(err_o),   DW'(1'b0));
      chk({tag, "_ready"}, DW'(ready_o), DW'(1'b1));
      chk({tag, "_data"},  data_o,       '0);
      m_flush();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) tick(1'b0, '0, rdy, 1'b0);
   endtask

   // Buffer 5 beats with 2 more still inside activation (ready_i low).
   task automatic fill_five_plus_two();
      for (int k = 0; k < 7; k++) tick(1'b1, junk(), 1'b0, 1'b0);
      chk("mid_fifo_level", DW'(m_fifo.size()), DW'(5));
      chk("mid_inflight", DW'(m_iss_cyc.size()), DW'(2));
   endtask

   // Fresh beat after a flush: exactly ACT_LATENCY+1 cycles to valid_o.
   task automatic fresh_beat(input string tag);
      logic [DW-1:0] p;
      int base;
      p = junk();
      base = pops;
      idle(4, 1'b1);
      chk({tag, "_no_ghost"}, DW'(pops - base), DW'(0));
      tick(1'b1, p, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk({tag, "_fresh_valid"}, DW'(valid_o), DW'(1'b1));
      chk({tag, "_fresh_data"}, data_o, p);
      idle(3, 1'b1);
   endtask

   initial begin
      int n_iss;
      int base;
      logic ce;
      logic clr;
      logic retile;
      logic [DW-1:0] p;

      n_cmp = 0; n_bad = 0; cyc = 0; pops = 0;
      m_bc = 0; m_err = 1'b0;
      rst_ni = 1'b1; clear_i = 1'b0; calc_en_i = 1'b0; ready_i = 1'b0;
      act_data_i = '0; tile_beats_i = 16'd1;
      #1;
      async_reset("rst");

      // Single beat, then a 2-beat tile held off by ready_i.
      tbl[0]  = '{1'b1, 8'h7F, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7F};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 8'hA1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[6]  = '{1'b1, 8'hB2, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'hB2};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      for (int i = 0; i < 12; i++) begin
         tile_beats_i = tbl[i].tile;
         chk($sformatf("tbl%0d_valid", i), DW'(valid_o), DW'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_last", i),  DW'(last_o),  DW'(tbl[i].e_last));
         chk($sformatf("tbl%0d_ready", i), DW'(ready_o), DW'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_err", i),   DW'(err_o),   DW'(tbl[i].e_err));
         if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), data_o, rep(tbl[i].e_lane));
         tick(tbl[i].ce, rep(tbl[i].lane), tbl[i].rdy, 1'b0);
      end

      // Streaming: 20 back-to-back beats, lane0 carries the index.
      tile_beats_i = 16'd20;
      base = pops;
      last_idx.delete();
      for (int i = 0; i < 20; i++) begin
         p = junk();
         p[7:0] = 8'(i);
         tick(1'b1, p, 1'b1, 1'b0);
      end
      idle(6, 1'b1);
      chk("stream_pops", DW'(pops - base), DW'(20));
      chk("stream_lasts", DW'(last_idx.size()), DW'(1));

      // Back-pressure: only 8 credits available with ready_i low.
      tile_beats_i = 16'd8;
      base = pops;
      n_iss = 0;
      for (int k = 0; k < 20; k++) begin
         ce = m_ready();
         tick(ce, junk(), 1'b0, 1'b0);
         if (ce) n_iss++;
      end
      chk("bp_issued", DW'(n_iss), DW'(8));
      chk("bp_ready_low", DW'(ready_o), DW'(1'b0));
      idle(12, 1'b1);
      chk("bp_pops", DW'(pops - base), DW'(8));
      chk("bp_ready_back", DW'(ready_o), DW'(1'b1));

      // Tiling: 4-beat tiles, ready_i toggling; last on pops 4, 8, 12.
      tile_beats_i = 16'd4;
      base = pops;
      last_idx.delete();
      n_iss = 0;
      for (int k = 0; k < 60; k++) begin
         ce = (n_iss < 12) && m_ready();
         tick(ce, junk(), 1'((k % 2) == 0), 1'b0);
         if (ce) n_iss++;
      end
      chk("tile_pops", DW'(pops - base), DW'(12));
      chk("tile_nlast", DW'(last_idx.size()), DW'(3));
      for (int j = 0; j < 3 && j < last_idx.size(); j++)
         chk($sformatf("tile_last%0d", j), DW'(last_idx[j] - base), DW'(4 * (j + 1)));
      chk("tile_cnt_zero", DW'(m_bc), DW'(0));

      // Overflow: FIFO full, one forced beat, error after the tap.
      tile_beats_i = 16'd8;
      for (int k = 0; k < 12; k++) tick(m_ready(), junk(), 1'b0, 1'b0);
      chk("ovf_full", DW'(m_fifo.size()), DW'(8));
      tick(1'b1, junk(), 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("ovf_err_before_tap", DW'(err_o), DW'(1'b0));
      idle(1, 1'b0);
      chk("ovf_err_set", DW'(err_o), DW'(1'b1));
      base = pops;
      idle(10, 1'b1);
      chk("ovf_pops", DW'(pops - base), DW'(8));
      chk("ovf_err_sticky", DW'(err_o), DW'(1'b1));
      tick(1'b0, '0, 1'b0, 1'b1);
      chk("ovf_err_cleared", DW'(err_o), DW'(1'b0));

      // Flush mid-stream with clear_i, then with rst_ni.
      fill_five_plus_two();
      tick(1'b0, '0, 1'b0, 1'b1);
      chk("clr_valid", DW'(valid_o), DW'(1'b0));
      chk("clr_ready", DW'(ready_o), DW'(1'b1));
      fresh_beat("clr");
      fill_five_plus_two();
      async_reset("midrst");
      fresh_beat("rst");

      // Randomized run with occasional protocol violations and clears.
      retile = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (retile) tile_beats_i = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 9) == 0) ce = 1'b1;
         else ce = m_ready() && ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 149) == 0);
         tick(ce, junk(), 1'($urandom_range(0, 2) != 0), clr);
         retile = clr;
      end
      idle(12, 1'b1);
      chk("final_empty", DW'(valid_o), DW'(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
